// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encoding, the NOP that sits in the instruction register after reset, and
// the default reset PC.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // issue request to instruction memory
      S_WAIT = 2'd1,   // request accepted, waiting for read data
      S_EXEC = 2'd2,   // instruction valid, waiting for decoder to retire it
      S_TRAP = 2'd3    // misaligned target seen, frozen until reset
   } state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
// Purely combinational next-PC selection. Priority is jalr, then jal, then a
// taken branch, then sequential. All sums wrap modulo 2^32.
//
// Ports
//   pc          in  32  current PC
//   jal/jalr/b  in   1  decoder control-flow type
//   comp        in   1  ALU compare result (branch taken when b & comp)
//   imm_j/imm_b in  32  sign-extended immediates
//   jalr_target in  32  rs1 + imm_i
//   next_pc     out 32  selected next PC
//   pc_plus4    out 32  pc + 4 (also the link value)
//   misalign    out  1  next_pc is not word aligned (bit 1 set)
// -----------------------------------------------------------------------------
module pc_next_mux (
   input  logic [31:0] pc,
   input  logic        jal,
   input  logic        jalr,
   input  logic        b,
   input  logic        comp,
   input  logic [31:0] imm_j,
   input  logic [31:0] imm_b,
   input  logic [31:0] jalr_target,
   output logic [31:0] next_pc,
   output logic [31:0] pc_plus4,
   output logic        misalign
);

   logic [31:0] w_pc_jal;
   logic [31:0] w_pc_br;

   assign pc_plus4 = pc + 32'd4;
   assign w_pc_jal = pc + imm_j;
   assign w_pc_br  = pc + imm_b;

   always_comb begin
      // NOTE: every output of an always_comb gets a default before any
      // branch, so no path can leave it unassigned and infer a latch.
      next_pc = pc_plus4;
      if (jalr) begin
         next_pc = {jalr_target[31:1], 1'b0};
      end else if (jal) begin
         next_pc = w_pc_jal;
      end else if (b && comp) begin
         next_pc = w_pc_br;
      end
   end

   // Bit 0 is already forced low for jalr and is zero in J/B immediates,
   // so only bit 1 can make a target misaligned.
   assign misalign = next_pc[1];

endmodule : pc_next_mux

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Single-outstanding instruction fetch: request at pc, wait for read data,
// hold the instruction for the decoder until it retires it, then advance pc.
// A misaligned control-flow target freezes the unit in S_TRAP until reset.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   enpc                       decoder: retire current instruction
//   jal, jalr, b, comp         decoder/ALU control-flow inputs
//   imm_j, imm_b, jalr_target  target operands
//   imem_req / imem_addr       request to instruction memory (addr = pc)
//   imem_gnt                   request accepted (sampled only in S_REQ)
//   imem_rvalid / imem_rdata   read response (sampled only in S_WAIT)
//   instr / instr_valid        registered instruction to the decoder
//   pc / pc_plus4              current PC and its link value
//   misalign                   sticky misaligned-target trap flag
//   retired                    retired instruction count (wraps)
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enpc,
   input  logic        jal,
   input  logic        jalr,
   input  logic        b,
   input  logic        comp,
   input  logic [31:0] imm_j,
   input  logic [31:0] imm_b,
   input  logic [31:0] jalr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        misalign,
   output logic [31:0] retired
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_instr_valid;
   logic        r_misalign;
   logic [31:0] r_retired;

   logic [31:0] w_next_pc;
   logic        w_next_misalign;
   logic        w_load_instr;   // capture read data this cycle
   logic        w_retire;       // advance pc and count
   logic        w_trap;         // enter S_TRAP

   pc_next_mux u_pc_next_mux (
      .pc          (r_pc),
      .jal         (jal),
      .jalr        (jalr),
      .b           (b),
      .comp        (comp),
      .imm_j       (imm_j),
      .imm_b       (imm_b),
      .jalr_target (jalr_target),
      .next_pc     (w_next_pc),
      .pc_plus4    (pc_plus4),
      .misalign    (w_next_misalign)
   );

   // State register.
   // NOTE: sequential state is written with non-blocking assignments so all
   // registers update together on the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control strobes. Decoder inputs only matter in S_EXEC
   // with enpc high; gnt only in S_REQ; rvalid only in S_WAIT.
   always_comb begin
      w_state_nxt  = r_state;
      w_load_instr = 1'b0;
      w_retire     = 1'b0;
      w_trap       = 1'b0;
      case (r_state)
         S_REQ: begin
            if (imem_gnt) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               w_load_instr = 1'b1;
               w_state_nxt  = S_EXEC;
            end
         end
         S_EXEC: begin
            if (enpc) begin
               if (w_next_misalign) begin
                  w_trap      = 1'b1;
                  w_state_nxt = S_TRAP;
               end else begin
                  w_retire    = 1'b1;
                  w_state_nxt = S_REQ;
               end
            end
         end
         S_TRAP: begin
            w_state_nxt = S_TRAP;
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase
   end

   // Datapath registers.
   // NOTE: rst_n is in the sensitivity list, so reset takes effect
   // immediately rather than waiting for the next clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_instr       <= NOP_INSTR;
         r_instr_valid <= 1'b0;
         r_misalign    <= 1'b0;
         r_retired     <= 32'd0;
      end else begin
         if (w_load_instr) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
         end
         if (w_retire) begin
            r_pc          <= w_next_pc;
            r_retired     <= r_retired + 32'd1;
            r_instr_valid <= 1'b0;
         end
         if (w_trap) begin
            r_misalign    <= 1'b1;
            r_instr_valid <= 1'b0;
         end
      end
   end

   assign imem_req    = (r_state == S_REQ);
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign pc          = r_pc;
   assign misalign    = r_misalign;
   assign retired     = r_retired;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Inputs change and outputs are sampled
// on the falling clock edge. Accepted fetches push {address, data} to a
// scoreboard queue, popped when the DUT presents the instruction.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enpc = 1'b0, jal = 1'b0, jalr = 1'b0, b = 1'b0, comp = 1'b0;
   logic [31:0] imm_j = '0, imm_b = '0, jalr_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc, pc_plus4;
   logic        misalign;
   logic [31:0] retired;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_pc      = RST_PC;
   logic [31:0] exp_retired = 32'd0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } fetch_t;
   fetch_t sb_q[$];

   typedef struct {
      string       name;
      logic [31:0] base;
      logic        jal, jalr, b, comp;
      logic [31:0] imm_j, imm_b, jalr_target;
      logic [31:0] exp_next;
   } vec_t;
   vec_t vecs[8];

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enpc        (enpc),
      .jal         (jal),
      .jalr        (jalr),
      .b           (b),
      .comp        (comp),
      .imm_j       (imm_j),
      .imm_b       (imm_b),
      .jalr_target (jalr_target),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .misalign    (misalign),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Asynchronous reset: values checked before any clock edge occurs.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_pc",          pc,          RST_PC);
      check("rst_instr",       instr,       NOP);
      check("rst_instr_valid", instr_valid, 32'd0);
      check("rst_misalign",    misalign,    32'd0);
      check("rst_retired",     retired,     32'd0);
      check("rst_imem_req",    imem_req,    32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_pc      = RST_PC;
      exp_retired = 32'd0;
      sb_q.delete();
   endtask

   // Fetch one instruction: grant after gnt_delay low cycles (with a stray
   // rvalid pulse in the first of them), data one cycle after grant.
   task automatic fetch(input logic [31:0] data, input int gnt_delay);
      fetch_t got;
      check("req_asserted", imem_req,  32'd1);
      check("req_addr",     imem_addr, exp_pc);
      check("pc_plus4",     pc_plus4,  exp_pc + 32'd4);
      for (int i = 0; i < gnt_delay; i++) begin
         imem_gnt    = 1'b0;
         imem_rvalid = (i == 0);
         imem_rdata  = 32'hDEAD_BEEF;
         @(negedge clk);
         check("req_held",      imem_req,    32'd1);
         check("req_addr_held", imem_addr,   exp_pc);
         check("no_early_valid", instr_valid, 32'd0);
      end
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b1;
      sb_q.push_back('{addr: exp_pc, data: data});
      @(negedge clk);
      imem_gnt = 1'b0;
      check("wait_req_low", imem_req, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      check("instr_valid", instr_valid, 32'd1);
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL sb_empty: got no entry expected one");
      end else begin
         got = sb_q.pop_front();
         check("sb_instr", instr, got.data);
         check("sb_pc",    pc,    got.addr);
      end
   endtask

   // Hold for 'stall' cycles with enpc low, then retire with the given
   // controls and check the PC lands on exp_next.
   task automatic execute(input vec_t v, input int stall);
      logic [31:0] held_instr;
      held_instr = instr;
      for (int i = 0; i < stall; i++) begin
         jal = 1'b1; jalr = 1'b1; b = 1'b1; comp = 1'b1;  // ignored without enpc
         jalr_target = 32'h0000_0222;
         @(negedge clk);
         check("stall_pc",      pc,          exp_pc);
         check("stall_instr",   instr,       held_instr);
         check("stall_retired", retired,     exp_retired);
         check("stall_valid",   instr_valid, 32'd1);
      end
      enpc = 1'b1;
      jal = v.jal; jalr = v.jalr; b = v.b; comp = v.comp;
      imm_j = v.imm_j; imm_b = v.imm_b; jalr_target = v.jalr_target;
      @(negedge clk);
      enpc = 1'b0; jal = 1'b0; jalr = 1'b0; b = 1'b0; comp = 1'b0;
      exp_pc      = v.exp_next;
      exp_retired = exp_retired + 32'd1;
      check({v.name, "_pc"},  pc,          exp_pc);
      check({v.name, "_ret"}, retired,     exp_retired);
      check({v.name, "_iv"},  instr_valid, 32'd0);
      check({v.name, "_req"}, imem_req,    32'd1);
   endtask

   // Reach an arbitrary aligned PC via a jalr retire.
   task automatic goto_pc(input logic [31:0] target);
      vec_t s;
      s = '{name: "goto", base: 0, jal: 0, jalr: 1, b: 0, comp: 0,
            imm_j: 0, imm_b: 0, jalr_target: target, exp_next: target};
      fetch(32'h0000_0067, 0);
      execute(s, 0);
   endtask

   initial begin
      vec_t plain;
      vecs[0] = '{"jalr_prio", 32'h100, 1, 1, 0, 0, 32'h40,        32'h0,  32'h205, 32'h204};
      vecs[1] = '{"jal_neg",   32'h100, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,  32'h0,   32'hF8};
      vecs[2] = '{"br_ntaken", 32'h40,  0, 0, 1, 0, 32'h0,         32'h10, 32'h0,   32'h44};
      vecs[3] = '{"br_taken",  32'h40,  0, 0, 1, 1, 32'h0,         32'h10, 32'h0,   32'h50};
      vecs[4] = '{"comp_only", 32'h40,  0, 0, 0, 1, 32'h0,         32'h10, 32'h0,   32'h44};
      vecs[5] = '{"jal_over_b",32'h200, 1, 0, 1, 1, 32'h1000,      32'h8,  32'h0,   32'h1200};
      vecs[6] = '{"pc_wrap",   32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,   32'h0};
      vecs[7] = '{"jalr_bit0", 32'h200, 0, 1, 0, 0, 32'h0,         32'h0,  32'h81,  32'h80};
      plain = '{name: "seq", base: 0, jal: 0, jalr: 0, b: 0, comp: 0,
                imm_j: 0, imm_b: 0, jalr_target: 0, exp_next: 32'h4};

      do_reset();

      // First fetch: immediate grant, data next cycle, retire sequentially.
      fetch(32'h0000_0033, 0);
      execute(plain, 0);

      // Slow grant with a stray rvalid in S_REQ, then a 4-cycle stall.
      plain.exp_next = 32'h8;
      fetch(32'h0000_1111, 5);
      execute(plain, 4);

      // Table-driven control-flow vectors.
      foreach (vecs[i]) begin
         goto_pc(vecs[i].base);
         fetch(32'h0000_0063 + i, 0);
         execute(vecs[i], 0);
      end

      // Misaligned jalr target: trap, frozen until reset.
      goto_pc(32'h10);
      fetch(32'h0000_0067, 0);
      enpc = 1'b1; jalr = 1'b1; jalr_target = 32'h22;
      @(negedge clk);
      enpc = 1'b0; jalr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         imem_gnt = 1'b1; imem_rvalid = 1'b1; enpc = 1'b1;
         check("trap_misalign", misalign,    32'd1);
         check("trap_pc",       pc,          32'h10);
         check("trap_req",      imem_req,    32'd0);
         check("trap_iv",       instr_valid, 32'd0);
         check("trap_retired",  retired,     exp_retired);
         @(negedge clk);
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; enpc = 1'b0;
      do_reset();
      check("post_trap_addr", imem_addr, RST_PC);

      // Reset during S_WAIT abandons the fetch.
      goto_pc(32'h300);
      check("pre_wait_req", imem_req, 32'd1);
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      check("in_wait_req", imem_req, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_wait_iv",  instr_valid, 32'd0);
      check("rst_wait_pc",  pc,          RST_PC);
      check("rst_wait_req", imem_req,    32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_pc = RST_PC; exp_retired = 32'd0; sb_q.delete();
      fetch(32'h0000_0033, 0);
      plain.exp_next = 32'h4;
      execute(plain, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enpc  input  1  decoder enable: retire current instruction and advance PC.
REQ-005 jal  input  1  decoder: unconditional PC-relative jump.
REQ-006 jalr  input  1  decoder: register-indirect jump.
REQ-007 b  input  1  decoder: conditional branch.
REQ-008 comp  input  1  ALU compare result; branch taken when b=1 and comp=1.
REQ-009 imm_j  input  32  sign-extended J-type immediate.
REQ-010 imm_b  input  32  sign-extended B-type immediate.
REQ-011 jalr_target  input  32  rs1+imm_i computed by ALU.
REQ-012 imem_req  output  1  instruction memory request.
REQ-013 imem_addr  output  32  request address; equals pc.
REQ-014 imem_gnt  input  1  memory accepts request this cycle.
REQ-015 imem_rvalid  input  1  read data valid.
REQ-016 imem_rdata  input  32  read data.
REQ-017 instr  output  32  registered instruction to decoder.
REQ-018 instr_valid  output  1  instr holds the instruction at pc.
REQ-019 pc  output  32  current PC.
REQ-020 pc_plus4  output  32  pc+4 for link write-back.
REQ-021 misalign  output  1  sticky trap flag: computed target not word-aligned.
REQ-022 retired  output  32  count of retired instructions.

Function
REQ-023 FSM states S_REQ, S_WAIT, S_EXEC, S_TRAP; S_REQ after reset.
REQ-024 S_REQ: imem_req=1, imem_addr=pc; imem_gnt=1 -> S_WAIT, else stay with request and address held stable.
REQ-025 S_WAIT: imem_req=0; imem_rvalid=1 -> instr<=imem_rdata, instr_valid<=1, -> S_EXEC; else stay, no timeout.
REQ-026 imem_rvalid outside S_WAIT ignored; imem_gnt outside S_REQ ignored.
REQ-027 S_EXEC: instr_valid=1; enpc=0 -> hold pc, instr, state (stall).
REQ-028 S_EXEC with enpc=1 and aligned next_pc: pc<=next_pc, retired<=retired+1, instr_valid<=0, -> S_REQ; minimum fetch-to-fetch period 3 cycles.
REQ-029 next_pc priority: jalr -> {jalr_target[31:1],1'b0}; else jal -> pc+imm_j; else b&comp -> pc+imm_b; else pc+4.
REQ-030 jal/jalr/b/comp ignored unless state is S_EXEC and enpc=1.
REQ-031 All PC arithmetic modulo 2^32; wrap-around without flag (32'hFFFF_FFFC+4 -> 0).
REQ-032 next_pc[1]=1 on enpc=1: pc and retired unchanged, misalign<=1, instr_valid<=0, -> S_TRAP.
REQ-033 S_TRAP: imem_req=0, instr_valid=0, all state held until reset.
REQ-034 retired wraps 32'hFFFF_FFFF -> 0.
REQ-035 pc_plus4 combinational from pc register, valid in every state.

Reset
REQ-036 rst_n low, asynchronously: pc=RESET_PC, state=S_REQ, instr=32'h0000_0013 (NOP), instr_valid=0, misalign=0, retired=0.
REQ-037 imem_req follows state decode; it reads 1 (S_REQ) during reset; memory shares rst_n so no pre-reset response arrives.
REQ-038 Reset mid-fetch (S_WAIT) or mid-stall abandons the transaction; first post-reset request address is RESET_PC.

Structure
REQ-039 Shared package holds FSM state enum, NOP constant 32'h0000_0013, default RESET_PC.
REQ-040 Next-PC selection and adders in one combinational sub-module pc_next_mux; FSM, PC, instr and counter registers in fetch_unit.

Verification
REQ-041 Reset, gnt=1 immediately, rvalid one cycle later with 32'h0000_0033 -> imem_addr=0, instr=32'h33 valid in cycle 3, enpc=1 -> pc=4, retired=1.
REQ-042 gnt held low 5 cycles -> imem_req=1, imem_addr stable at 0 throughout; rvalid pulsed during S_REQ ignored.
REQ-043 pc=0x100, jal=1 jalr=1, jalr_target=0x205 -> pc=0x204 (jalr priority, bit0 cleared); jal=1, imm_j=-8 at pc=0x100 -> pc=0xF8.
REQ-044 pc=0x40, b=1: comp=0 -> 0x44; comp=1, imm_b=0x10 -> 0x50; enpc=0 for 4 cycles -> pc, instr, retired unchanged.
REQ-045 pc=0x10, jalr_target=0x22 -> misalign=1, pc stays 0x10, imem_req=0 until rst_n low, then pc=RESET_PC, misalign=0.
REQ-046 pc=32'hFFFF_FFFC sequential retire -> pc=0; rst_n asserted during S_WAIT -> instr_valid=0 same cycle, next request at RESET_PC.
